// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for k*P, driving a shared external
// point-addition unit through a one-cycle launch pulse and a ready/inf handshake.
//
// state        | meaning
// S_IDLE       | waiting for start; result outputs held
// S_SCAN       | bit i: double R if finite, else evaluate the bit directly
// S_DBL_LAUNCH | pa_reset pulse with operands (R, R)
// S_DBL_WAIT   | wait for unit; first cycle ignored (stale flags)
// S_ADD_LAUNCH | pa_reset pulse with operands (R, P)
// S_ADD_WAIT   | wait for unit; first cycle ignored (stale flags)
// S_NEXT       | retire bit i after an addition
// S_FIN        | publish R, pulse done
module scalar_mult_ctrl #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] k,
  input  logic [n-1:0] xp,
  input  logic [n-1:0] yp,
  input  logic [n-1:0] p,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out,
  output logic         inf_out,
  output logic         pa_reset,
  output logic [n-1:0] pa_x1,
  output logic [n-1:0] pa_y1,
  output logic [n-1:0] pa_x2,
  output logic [n-1:0] pa_y2,
  output logic [n-1:0] pa_p,
  input  logic [n-1:0] pa_x3,
  input  logic [n-1:0] pa_y3,
  input  logic         pa_ready,
  input  logic         pa_inf
);

  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_DBL_LAUNCH, S_DBL_WAIT,
    S_ADD_LAUNCH, S_ADD_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [n-1:0]   k_q, k_d, xp_q, xp_d, yp_q, yp_d;
  logic [n-1:0]   rx_q, rx_d, ry_q, ry_d;
  logic           rinf_q, rinf_d;
  logic           first_q, first_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [n-1:0]   x_out_q, x_out_d, y_out_q, y_out_d;
  logic           inf_out_q, inf_out_d;
  logic           pa_reset_q, pa_reset_d;
  logic [n-1:0]   pa_x1_q, pa_x1_d, pa_y1_q, pa_y1_d;
  logic [n-1:0]   pa_x2_q, pa_x2_d, pa_y2_q, pa_y2_d;
  logic           eval_bit, retire;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    k_d        = k_q;
    xp_d       = xp_q;
    yp_d       = yp_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    rinf_d     = rinf_q;
    first_d    = first_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    inf_out_d  = inf_out_q;
    pa_reset_d = 1'b0;
    pa_x1_d    = pa_x1_q;
    pa_y1_d    = pa_y1_q;
    pa_x2_d    = pa_x2_q;
    pa_y2_d    = pa_y2_q;
    eval_bit   = 1'b0;
    retire     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = k;
          xp_d    = xp;
          yp_d    = yp;
          idx_d   = IW'(n - 1);
          rx_d    = '0;
          ry_d    = '0;
          rinf_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!rinf_q) state_d = S_DBL_LAUNCH;
        else         eval_bit = 1'b1;
      end
      S_DBL_LAUNCH: begin
        first_d = 1'b1;
        state_d = S_DBL_WAIT;
      end
      S_ADD_LAUNCH: begin
        first_d = 1'b1;
        state_d = S_ADD_WAIT;
      end
      S_DBL_WAIT, S_ADD_WAIT: begin
        first_d = 1'b0;
        if (!first_q && (pa_inf || pa_ready)) begin
          if (pa_inf) begin
            rinf_d = 1'b1;
          end else begin
            rx_d   = pa_x3;
            ry_d   = pa_y3;
            rinf_d = 1'b0;
          end
          if (state_q == S_DBL_WAIT) eval_bit = 1'b1;
          else                       state_d  = S_NEXT;
        end
      end
      S_NEXT: retire = 1'b1;
      S_FIN: begin
        x_out_d   = rinf_q ? '0 : rx_q;
        y_out_d   = rinf_q ? '0 : ry_q;
        inf_out_d = rinf_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bit evaluation retires the bit itself when no unit operation is needed,
    // so a run of leading zeros costs one cycle per bit.
    if (eval_bit) begin
      if (k_q[idx_q]) begin
        if (rinf_d) begin
          rx_d   = xp_q;
          ry_d   = yp_q;
          rinf_d = 1'b0;
          retire = 1'b1;
        end else begin
          state_d = S_ADD_LAUNCH;
        end
      end else begin
        retire = 1'b1;
      end
    end

    if (retire) begin
      if (idx_q == '0) begin
        state_d = S_FIN;
      end else begin
        idx_d   = idx_q - 1'b1;
        state_d = S_SCAN;
      end
    end

    // Operands are registered on entry to a launch state and then held.
    if (state_d == S_DBL_LAUNCH) begin
      pa_x1_d    = rx_d;
      pa_y1_d    = ry_d;
      pa_x2_d    = rx_d;
      pa_y2_d    = ry_d;
      pa_reset_d = 1'b1;
    end else if (state_d == S_ADD_LAUNCH) begin
      pa_x1_d    = rx_d;
      pa_y1_d    = ry_d;
      pa_x2_d    = xp_q;
      pa_y2_d    = yp_q;
      pa_reset_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      k_q        <= '0;
      xp_q       <= '0;
      yp_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      rinf_q     <= 1'b0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      inf_out_q  <= 1'b0;
      pa_reset_q <= 1'b0;
      pa_x1_q    <= '0;
      pa_y1_q    <= '0;
      pa_x2_q    <= '0;
      pa_y2_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      xp_q       <= xp_d;
      yp_q       <= yp_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      rinf_q     <= rinf_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      inf_out_q  <= inf_out_d;
      pa_reset_q <= pa_reset_d;
      pa_x1_q    <= pa_x1_d;
      pa_y1_q    <= pa_y1_d;
      pa_x2_q    <= pa_x2_d;
      pa_y2_q    <= pa_y2_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign x_out    = x_out_q;
  assign y_out    = y_out_q;
  assign inf_out  = inf_out_q;
  assign pa_reset = pa_reset_q;
  assign pa_x1    = pa_x1_q;
  assign pa_y1    = pa_y1_q;
  assign pa_x2    = pa_x2_q;
  assign pa_y2    = pa_y2_q;
  assign pa_p     = p;

endmodule
